bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Central arbiter for the shared serial data bus that the slave modules sit on.
- Grants bus ownership to one of NUM_MASTERS masters using round-robin priority, and drives bus_util, which slaves use to leave their peer-wait state.
- Holds the grant while any slave asserts slave_busy, so a transaction is never cut mid-handshake.
- A hold-time watchdog forcibly reclaims the bus from a hung master.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (>=2).
- ID_WIDTH, $clog2(NUM_MASTERS), width of owner/timeout IDs.
- TIMEOUT_CYCLES, 255, maximum cycles a grant may be held before forced release (>=4).
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), hold-counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_MASTERS  per-master bus request, level.
- done  input  NUM_MASTERS  per-master end-of-transaction pulse; only the owner's bit is used.
- slave_busy  input  1  wired-OR busy line from the slaves (Z reads as 0).
- grant  output  NUM_MASTERS  one-hot ownership, registered.
- bus_util  output  1  bus in use; high exactly while grant is non-zero.
- owner_id  output  ID_WIDTH  index of current or most recent owner.
- timeout  output  1  one-cycle pulse on forced release.
- timeout_id  output  ID_WIDTH  master index reclaimed by the last timeout.

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - grant=0, bus_util=0, timeout=0, owner_id=0, timeout_id=0.
  - Hold counter=0, state=IDLE.
  - Internal last_owner=NUM_MASTERS-1, so master 0 has top priority after reset.
- States: IDLE, ACTIVE, WAIT_SLAVE, RELEASE, TIMEOUT.
- IDLE:
  - grant=0, bus_util=0.
  - If req!=0, select the first set bit searching upward from last_owner+1 with wrap-around.
  - Next cycle: grant[sel]=1, bus_util=1, owner_id=sel, counter=0, go to ACTIVE.
  - Latency from req sampled high to grant high is 1 cycle.
- ACTIVE:
  - Counter increments each cycle, saturating at TIMEOUT_CYCLES.
  - done[owner]=1 or req[owner]=0 (abort) is a release event.
  - Release event with slave_busy=0: go to RELEASE.
  - Release event with slave_busy=1: go to WAIT_SLAVE; grant is held.
- WAIT_SLAVE:
  - Grant held and counter keeps running.
  - On the first cycle slave_busy=0, go to RELEASE.
- RELEASE:
  - grant=0, bus_util=0 for exactly 1 cycle (turnaround, so slaves return to IDLE).
  - last_owner=owner_id, then go to IDLE.
  - No new grant is possible in the RELEASE cycle; the minimum gap between grants is 1 cycle with bus_util low.
- Timeout:
  - In ACTIVE or WAIT_SLAVE, if counter==TIMEOUT_CYCLES-1 and there is no release event this cycle, go to TIMEOUT.
  - Next cycle: grant=0, bus_util=0, timeout=1, timeout_id=owner_id, last_owner=owner_id.
  - Then go to IDLE; timeout returns to 0.
  - Maximum hold is therefore TIMEOUT_CYCLES cycles of grant high.
  - Slave_busy does not extend past the timeout.
- Simultaneous events:
  - A release event and timeout in the same cycle: release wins, no timeout pulse.
  - done from a non-owner is ignored.
  - Multiple done bits: only done[owner_id] is considered.
- Fairness: with every master requesting continuously, grants rotate 0,1,...,N-1,0,...
  - A timed-out master becomes lowest priority on the next arbitration.
- Invariants (must hold every cycle):
  - grant is one-hot or zero.
  - bus_util == |grant.
  - owner_id is stable whenever grant!=0.

Test Plan:
- Reset, then req=2'b10 -> grant=2'b10 and bus_util=1 one cycle later, owner_id=1; done[1] pulse with slave_busy=0 -> next cycle grant=0; following cycle still 0; IDLE.
- req=2'b11 held constantly, each owner pulses done 3 cycles after grant -> grant sequence 01,00,10,00,01,...; every grant lasts 4 cycles; 1-cycle gap with bus_util=0.
- Owner 0 pulses done while slave_busy=1 for 5 more cycles -> grant stays 01 through those 5 cycles; RELEASE on the cycle after slave_busy falls.
- TIMEOUT_CYCLES=8, owner 0 never pulses done -> grant high exactly 8 cycles; then grant=0 with timeout=1 for 1 cycle and timeout_id=0; a pending req[1] is granted next.
- done[owner] arrives on the exact timeout cycle -> normal release, timeout stays 0.
- Assert rst mid-ACTIVE and mid-WAIT_SLAVE -> grant, bus_util and timeout go 0 asynchronously; after rst deasserts with req=2'b11, master 0 is granted first.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared serial slave bus.
// Grants one master at a time, holds the grant while any slave reports busy,
// and forcibly reclaims the bus when a master holds it for too long.
module bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ID_WIDTH       = $clog2(NUM_MASTERS),
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [NUM_MASTERS-1:0] done_i,
  input  logic                   slave_busy_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   bus_util_o,
  output logic [ID_WIDTH-1:0]    owner_id_o,
  output logic                   timeout_o,
  output logic [ID_WIDTH-1:0]    timeout_id_o
);

  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    WAIT_SLAVE,
    RELEASE,
    TIMEOUT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CntMax  = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_WIDTH-1:0]  LastId  = ID_WIDTH'(NUM_MASTERS - 1);

  state_t                   state_q;
  logic [NUM_MASTERS-1:0]   grant_q;
  logic [ID_WIDTH-1:0]      owner_id_q;
  logic [ID_WIDTH-1:0]      last_owner_q;
  logic [ID_WIDTH-1:0]      timeout_id_q;
  logic                     timeout_q;
  logic [CNT_WIDTH-1:0]     cnt_q;
  logic [CNT_WIDTH-1:0]     cnt_d;

  logic [ID_WIDTH-1:0]      cand;
  logic [ID_WIDTH-1:0]      selIdx;
  logic                     selValid;
  logic                     releaseEvt;
  logic                     holdExpired;

  // Round-robin pick: first requester searching upward from last_owner+1, wrapping.
  always_comb begin
    cand     = '0;
    selIdx   = '0;
    selValid = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = ID_WIDTH'((int'(last_owner_q) + i) % NUM_MASTERS);
      if (!selValid && req_i[cand]) begin
        selValid = 1'b1;
        selIdx   = cand;
      end
    end
  end

  // Owner-side release, hold-counter increment and watchdog expiry detection.
  always_comb begin
    releaseEvt  = done_i[owner_id_q] | ~req_i[owner_id_q];
    cnt_d       = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    holdExpired = (cnt_q == CntLast);
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_id_q   <= '0;
      last_owner_q <= LastId;
      timeout_id_q <= '0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, RELEASE, TIMEOUT: begin
          if (selValid) begin
            grant_q    <= NUM_MASTERS'(1) << selIdx;
            owner_id_q <= selIdx;
            cnt_q      <= '0;
            state_q    <= ACTIVE;
          end else begin
            state_q <= IDLE;
          end
        end
        ACTIVE: begin
          cnt_q <= cnt_d;
          if (releaseEvt) begin
            if (slave_busy_i) begin
              state_q <= WAIT_SLAVE;
            end else begin
              grant_q      <= '0;
              last_owner_q <= owner_id_q;
              state_q      <= RELEASE;
            end
          end else if (holdExpired) begin
            grant_q      <= '0;
            timeout_q    <= 1'b1;
            timeout_id_q <= owner_id_q;
            last_owner_q <= owner_id_q;
            state_q      <= TIMEOUT;
          end
        end
        WAIT_SLAVE: begin
          cnt_q <= cnt_d;
          if (!slave_busy_i) begin
            grant_q      <= '0;
            last_owner_q <= owner_id_q;
            state_q      <= RELEASE;
          end else if (holdExpired) begin
            grant_q      <= '0;
            timeout_q    <= 1'b1;
            timeout_id_q <= owner_id_q;
            last_owner_q <= owner_id_q;
            state_q      <= TIMEOUT;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant_o      = grant_q;
  assign bus_util_o   = |grant_q;
  assign owner_id_o   = owner_id_q;
  assign timeout_o    = timeout_q;
  assign timeout_id_o = timeout_id_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with two masters and an 8-cycle watchdog.
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] done;
  logic       slaveBusy;
  logic [1:0] grant;
  logic       busUtil;
  logic [0:0] ownerId;
  logic       timeout;
  logic [0:0] timeoutId;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(
    .NUM_MASTERS   (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .done_i      (done),
    .slave_busy_i(slaveBusy),
    .grant_o     (grant),
    .bus_util_o  (busUtil),
    .owner_id_o  (ownerId),
    .timeout_o   (timeout),
    .timeout_id_o(timeoutId)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] d, input logic b);
    req       = r;
    done      = d;
    slaveBusy = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants sampled mid-cycle: one-hot-or-zero grant, bus_util tracks grant.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("inv_util", 32'(busUtil), 32'(|grant));
      checkOutput("inv_onehot", 32'($onehot0(grant)), 32'd1);
    end
  end

  initial begin
    logic [1:0] eg;
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 1'b0);
    #12;
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_util", 32'(busUtil), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    checkOutput("rst_owner", 32'(ownerId), 32'd0);
    checkOutput("rst_tid", 32'(timeoutId), 32'd0);
    rst = 1'b0;

    // Single request from master 1, then done with idle slaves.
    applyStimulus(2'b10, 2'b00, 1'b0);
    tick();
    checkOutput("t1_grant", 32'(grant), 32'h2);
    checkOutput("t1_util", 32'(busUtil), 32'd1);
    checkOutput("t1_owner", 32'(ownerId), 32'd1);
    applyStimulus(2'b10, 2'b10, 1'b0);
    tick();
    checkOutput("t1_release", 32'(grant), 32'd0);
    applyStimulus(2'b00, 2'b00, 1'b0);
    tick();
    checkOutput("t1_idle", 32'(grant), 32'd0);
    checkOutput("t1_idle_util", 32'(busUtil), 32'd0);

    // Both masters requesting; done in the fourth grant cycle gives 4-on / 1-off rotation.
    applyStimulus(2'b11, 2'b00, 1'b0);
    for (int g = 0; g < 4; g++) begin
      eg = (g % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      checkOutput("fair_owner", 32'(ownerId), 32'(g % 2));
      for (int c = 0; c < 4; c++) begin
        checkOutput("fair_grant", 32'(grant), 32'(eg));
        if (c < 3) tick();
      end
      done = eg;
      tick();
      checkOutput("fair_gap", 32'(grant), 32'd0);
      checkOutput("fair_gap_util", 32'(busUtil), 32'd0);
      done = 2'b00;
    end

    // Master 0 finishes while a slave is still busy: grant held until busy drops.
    tick();
    checkOutput("busy_grant0", 32'(grant), 32'h1);
    applyStimulus(2'b11, 2'b01, 1'b1);
    tick();
    done = 2'b00;
    checkOutput("busy_hold", 32'(grant), 32'h1);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("busy_hold", 32'(grant), 32'h1);
    end
    slaveBusy = 1'b0;
    tick();
    checkOutput("busy_release", 32'(grant), 32'd0);
    tick();
    checkOutput("busy_next", 32'(grant), 32'h2);
    applyStimulus(2'b00, 2'b10, 1'b0);
    tick();
    checkOutput("busy_next_rel", 32'(grant), 32'd0);
    done = 2'b00;
    tick();

    // Master 0 hangs: exactly 8 cycles of grant, then a timeout pulse, then master 1.
    applyStimulus(2'b11, 2'b00, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick();
      checkOutput("to_hold", 32'(grant), 32'h1);
      checkOutput("to_nopulse", 32'(timeout), 32'd0);
    end
    tick();
    checkOutput("to_grant", 32'(grant), 32'd0);
    checkOutput("to_pulse", 32'(timeout), 32'd1);
    checkOutput("to_id", 32'(timeoutId), 32'd0);
    tick();
    checkOutput("to_next", 32'(grant), 32'h2);
    checkOutput("to_pulse_end", 32'(timeout), 32'd0);
    checkOutput("to_next_owner", 32'(ownerId), 32'd1);

    // Master 1 signals done on the very cycle its hold would expire.
    for (int c = 0; c < 7; c++) begin
      tick();
      checkOutput("edge_hold", 32'(grant), 32'h2);
    end
    done = 2'b10;
    tick();
    checkOutput("edge_release", 32'(grant), 32'd0);
    checkOutput("edge_nopulse", 32'(timeout), 32'd0);
    done = 2'b00;
    tick();
    checkOutput("edge_next", 32'(grant), 32'h1);

    // Asynchronous reset while waiting on a busy slave.
    applyStimulus(2'b11, 2'b01, 1'b1);
    tick();
    done = 2'b00;
    checkOutput("rw_hold", 32'(grant), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rw_grant", 32'(grant), 32'd0);
    checkOutput("rw_util", 32'(busUtil), 32'd0);
    checkOutput("rw_timeout", 32'(timeout), 32'd0);
    #1;
    rst = 1'b0;
    applyStimulus(2'b11, 2'b00, 1'b0);
    tick();
    checkOutput("rw_first", 32'(grant), 32'h1);

    // Asynchronous reset while master 1 owns the bus; master 0 must win afterwards.
    done = 2'b01;
    tick();
    done = 2'b00;
    checkOutput("ra_rel", 32'(grant), 32'd0);
    tick();
    checkOutput("ra_owner1", 32'(grant), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ra_grant", 32'(grant), 32'd0);
    checkOutput("ra_util", 32'(busUtil), 32'd0);
    checkOutput("ra_owner", 32'(ownerId), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    checkOutput("ra_first", 32'(grant), 32'h1);
    checkOutput("ra_first_owner", 32'(ownerId), 32'd0);

    applyStimulus(2'b00, 2'b00, 1'b0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
